// File: rtl/spi_frame_sched.sv
// spi_frame_sched
// Loads one duty byte per zone into an external zone register bank, then
// reserves a fixed number of clocks for the downstream SPI shift before
// reporting the frame as complete.
//
// Ports
//   clock        sole clock, all flops rising-edge
//   reset        asynchronous active-low reset
//   frame_start  one-cycle frame request pulse
//   duty_valid   duty byte available
//   duty_data    duty byte for the current zone
//   duty_ready   high while the scheduler is fetching zone bytes
//   DATAout      {zone address, duty byte} for the zone register bank
//   ENC          one-cycle load enable for the zone register bank
//   zone_idx     index of the next zone to be accepted
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle completion pulse
//   overrun      sticky: frame_start seen while a frame was in progress
//   clr_ovr      synchronous clear of overrun
module spi_frame_sched #(
    parameter int         NUM_ZONES   = 10,
    parameter logic [7:0] ZONE_BASE   = 8'h00,
    parameter int         XFER_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        duty_valid,
    input  logic [7:0]  duty_data,
    output logic        duty_ready,
    output logic [15:0] DATAout,
    output logic        ENC,
    output logic [3:0]  zone_idx,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    input  logic        clr_ovr
);

    typedef enum logic [1:0] {IDLE, FETCH, XFER, DONE} state_t;

    localparam logic [3:0]  LAST_ZONE = 4'(NUM_ZONES - 1);
    localparam logic [15:0] XFER_LOAD = 16'(XFER_CYCLES);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_xferCnt;
    logic [3:0]  r_zoneIdx;
    logic [15:0] r_dataOut;
    logic        r_enc;
    logic        r_overrun;
    logic        w_ready;
    logic        w_busy;
    logic        w_done;
    logic        w_handshake;
    logic        w_lastZone;
    logic [7:0]  w_zoneAddr;

    assign w_handshake = duty_valid & w_ready;
    assign w_lastZone  = (r_zoneIdx == LAST_ZONE);
    // Address wraps modulo 256 when ZONE_BASE sits near the top of the map.
    assign w_zoneAddr  = ZONE_BASE + {4'b0000, r_zoneIdx};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. FETCH waits indefinitely on duty_valid; XFER leaves
    // when the counter is about to expire so XFER lasts exactly XFER_CYCLES.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_nextState = FETCH;
            FETCH:   if (w_handshake && w_lastZone) w_nextState = XFER;
            XFER:    if (r_xferCnt == 16'd1) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE:    w_busy  = 1'b0;
            FETCH:   w_ready = 1'b1;
            DONE:    w_done  = 1'b1;
            default: ;
        endcase
    end

    // Zone datapath and XFER counter. ENC is registered so the bank sees
    // address and data stable for the whole enable cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_zoneIdx <= 4'd0;
            r_dataOut <= 16'h0000;
            r_enc     <= 1'b0;
            r_xferCnt <= 16'd0;
        end else begin
            r_enc <= w_handshake;
            if (r_state == IDLE && frame_start) begin
                r_zoneIdx <= 4'd0;
            end else if (w_handshake) begin
                r_zoneIdx <= r_zoneIdx + 4'd1;
                r_dataOut <= {w_zoneAddr, duty_data};
            end
            if (r_state == FETCH && w_nextState == XFER) begin
                r_xferCnt <= XFER_LOAD;
            end else if (r_state == XFER) begin
                r_xferCnt <= r_xferCnt - 16'd1;
            end
        end
    end

    // Sticky overrun; a new violation on the same edge beats the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (frame_start && r_state != IDLE) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign duty_ready = w_ready;
    assign busy       = w_busy;
    assign frame_done = w_done;
    assign DATAout    = r_dataOut;
    assign ENC        = r_enc;
    assign zone_idx   = r_zoneIdx;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_frame_sched.sv
// tb_spi_frame_sched
// Two schedulers share one stimulus stream: the default configuration and a
// corner configuration (one zone, one-cycle transfer, base address 8'hFF).
// Each has a frame-level reference model that predicts load events and
// completion times; a monitor per instance pops those predictions whenever
// the scheduler presents ENC or frame_done.
module tb_spi_frame_sched;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } encEvt_t;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       frame_start = 1'b0;
    logic       duty_valid  = 1'b0;
    logic       clr_ovr     = 1'b0;
    logic [7:0] duty_data   = 8'h00;

    logic [1:0]       readyA;
    logic [1:0]       encA;
    logic [1:0]       busyA;
    logic [1:0]       doneA;
    logic [1:0]       ovrA;
    logic [1:0][15:0] doutA;
    logic [1:0][3:0]  zoneA;

    int   assertCount = 0;
    int   failCount   = 0;
    event endEv;

    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d t=%0t actual=%0h required=%0h",
                     name, d, $time, actual, expected);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gDut
        localparam int         NZ   = (g == 0) ? 10 : 1;
        localparam int         XC   = (g == 0) ? 64 : 1;
        localparam logic [7:0] BASE = (g == 0) ? 8'h00 : 8'hFF;

        encEvt_t     encQ[$];
        int          doneQ[$];
        int          cyc      = 0;
        int          taken    = 0;
        int          freeEdge = 0;
        bit          inFrame  = 1'b0;
        bit          expOvr   = 1'b0;
        logic [15:0] lastData = 16'h0000;

        spi_frame_sched #(
            .NUM_ZONES  (NZ),
            .ZONE_BASE  (BASE),
            .XFER_CYCLES(XC)
        ) dut (
            .clock      (clock),
            .reset      (reset),
            .frame_start(frame_start),
            .duty_valid (duty_valid),
            .duty_data  (duty_data),
            .duty_ready (readyA[g]),
            .DATAout    (doutA[g]),
            .ENC        (encA[g]),
            .zone_idx   (zoneA[g]),
            .busy       (busyA[g]),
            .frame_done (doneA[g]),
            .overrun    (ovrA[g]),
            .clr_ovr    (clr_ovr)
        );

        // Frame-level model: a frame runs from its start edge until XC+1
        // edges after its last accepted byte; completion is due XC edges
        // after that byte.
        always @(posedge clock) begin
            bit      wasIdle;
            encEvt_t e;
            cyc++;
            if (!reset) begin
                inFrame  = 1'b0;
                taken    = 0;
                expOvr   = 1'b0;
                lastData = 16'h0000;
                encQ.delete();
                doneQ.delete();
            end else begin
                wasIdle = !inFrame || (taken == NZ && cyc >= freeEdge);
                if (!wasIdle && taken < NZ && duty_valid) begin
                    e.cyc  = cyc;
                    e.data = {8'(BASE + taken), duty_data};
                    encQ.push_back(e);
                    taken++;
                    if (taken == NZ) begin
                        freeEdge = cyc + XC + 2;
                        doneQ.push_back(cyc + XC);
                    end
                end
                if (frame_start && !wasIdle) expOvr = 1'b1;
                else if (clr_ovr)            expOvr = 1'b0;
                if (frame_start && wasIdle) begin
                    inFrame = 1'b1;
                    taken   = 0;
                end else if (wasIdle) begin
                    inFrame = 1'b0;
                end
            end
        end

        // Monitor: pops predictions when the scheduler presents events and
        // checks the status outputs every cycle.
        always @(negedge clock) begin
            encEvt_t e;
            int      dc;
            bit      expBusy;
            if (reset) begin
                if (encA[g]) begin
                    if (encQ.size() == 0) begin
                        checkOutput("enc_unexpected", g, 32'(encA[g]), 0);
                    end else begin
                        e = encQ.pop_front();
                        checkOutput("enc_cycle", g, cyc, e.cyc);
                        checkOutput("dataout", g, 32'(doutA[g]), 32'(e.data));
                        lastData = e.data;
                    end
                end else begin
                    checkOutput("dataout_hold", g, 32'(doutA[g]), 32'(lastData));
                    if (encQ.size() > 0 && encQ[0].cyc <= cyc) begin
                        checkOutput("enc_missing", g, 32'(encA[g]), 1);
                        void'(encQ.pop_front());
                    end
                end
                if (doneA[g]) begin
                    if (doneQ.size() == 0) begin
                        checkOutput("done_unexpected", g, 32'(doneA[g]), 0);
                    end else begin
                        dc = doneQ.pop_front();
                        checkOutput("done_cycle", g, cyc, dc);
                    end
                end else if (doneQ.size() > 0 && doneQ[0] <= cyc) begin
                    checkOutput("done_missing", g, 32'(doneA[g]), 1);
                    void'(doneQ.pop_front());
                end
                expBusy = inFrame && !(taken == NZ && cyc + 1 >= freeEdge);
                checkOutput("busy", g, 32'(busyA[g]), 32'(expBusy));
                checkOutput("duty_ready", g, 32'(readyA[g]), 32'(inFrame && taken < NZ));
                checkOutput("zone_idx", g, 32'(zoneA[g]), taken);
                checkOutput("overrun", g, 32'(ovrA[g]), 32'(expOvr));
            end
        end

        initial begin
            @(endEv);
            checkOutput("enc_leftover", g, encQ.size(), 0);
            checkOutput("done_leftover", g, doneQ.size(), 0);
        end
    end

    task automatic applyStimulus(input logic fs, input logic dv,
                                 input logic [7:0] dd, input logic co);
        frame_start = fs;
        duty_valid  = dv;
        duty_data   = dd;
        clr_ovr     = co;
        @(posedge clock);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendBytes(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, first + 8'(i), 1'b0);
    endtask

    task automatic checkResetValues();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_enc", d, 32'(encA[d]), 0);
            checkOutput("rst_dataout", d, 32'(doutA[d]), 0);
            checkOutput("rst_zone_idx", d, 32'(zoneA[d]), 0);
            checkOutput("rst_busy", d, 32'(busyA[d]), 0);
            checkOutput("rst_duty_ready", d, 32'(readyA[d]), 0);
            checkOutput("rst_frame_done", d, 32'(doneA[d]), 0);
            checkOutput("rst_overrun", d, 32'(ovrA[d]), 0);
        end
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic pulseReset();
        reset = 1'b0;
        #1;
        checkResetValues();
        idleCycles(2);
        reset = 1'b1;
    endtask

    initial begin
        #2;
        pulseReset();
        idleCycles(2);

        // duty_valid held while idle must not load anything
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);

        // full frame, consecutive bytes 8'h10..8'h19
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(10, 8'h10);
        idleCycles(70);

        // five-cycle gap after zone 3
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(4, 8'h20);
        idleCycles(5);
        sendBytes(6, 8'h24);
        idleCycles(70);

        // frame_start during XFER together with clr_ovr: set wins
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(10, 8'h30);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        idleCycles(70);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        idleCycles(2);

        // start plus clear in IDLE
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(10, 8'h40);
        idleCycles(5);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        idleCycles(70);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        sendBytes(10, 8'h50);
        idleCycles(70);

        // reset mid-frame after zone 5, then a fresh frame from zone 0
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(6, 8'h60);
        pulseReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        sendBytes(10, 8'h70);
        idleCycles(70);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
                          8'($urandom), $urandom_range(0, 99) < 5);
        end
        idleCycles(80);

        ->endEv;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
